// File: rtl/decode_if.sv
// Fetch/decode handshake bundle: fetch-side inputs, downstream control and
// the decoded output register of the decode stage.
interface decode_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  i_valid;
    logic [WORD_WIDTH-1:0] i_inst;
    logic [ADDR_WIDTH-1:0] i_next_pc;
    logic                  i_stall;
    logic                  i_flush;

    logic                  o_valid;
    logic [5:0]            o_opcode;
    logic [4:0]            o_rd;
    logic [4:0]            o_rs1;
    logic [4:0]            o_rs2;
    logic [WORD_WIDTH-1:0] o_imm;
    logic [ADDR_WIDTH-1:0] o_pc;
    logic                  o_illegal;
    logic                  o_redirect;
    logic [ADDR_WIDTH-1:0] o_redirect_pc;
    logic                  o_stall_fetch;

    // Fetch and pipeline control side
    modport master (
        output i_valid, i_inst, i_next_pc, i_stall, i_flush,
        input  o_valid, o_opcode, o_rd, o_rs1, o_rs2, o_imm, o_pc,
               o_illegal, o_redirect, o_redirect_pc, o_stall_fetch
    );

    // Decode stage side
    modport slave (
        input  i_valid, i_inst, i_next_pc, i_stall, i_flush,
        output o_valid, o_opcode, o_rd, o_rs1, o_rs2, o_imm, o_pc,
               o_illegal, o_redirect, o_redirect_pc, o_stall_fetch
    );
endinterface

// File: rtl/decode.sv
// Decode stage: one registered output set (latency 1), JMP redirect,
// illegal-opcode flag and fetch stall. Defining DECODE_HAZARD_EN adds
// load-use hazard detection with a RUN/HOLD FSM and a one-entry skid buffer.
module decode #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32
) (
    input logic     i_clk,
    input logic     i_rst,
    decode_if.slave bus
);
    typedef enum logic [5:0] {
        OP_NOP   = 6'h00,
        OP_ALU   = 6'h01,
        OP_JMP   = 6'h02,
        OP_LOAD  = 6'h03,
        OP_STORE = 6'h04
    } opcode_t;

    localparam logic [ADDR_WIDTH-1:0] INST_BYTES = ADDR_WIDTH'(WORD_WIDTH / 8);

    logic                  out_valid;
    logic [5:0]            out_opcode;
    logic [4:0]            out_rd;
    logic [4:0]            out_rs1;
    logic [4:0]            out_rs2;
    logic [WORD_WIDTH-1:0] out_imm;
    logic [ADDR_WIDTH-1:0] out_pc;

    logic                  in_valid;
    logic [WORD_WIDTH-1:0] in_inst;
    logic [ADDR_WIDTH-1:0] in_next_pc;
    logic                  hazard;
    logic                  redirect;
    logic                  illegal;
    logic                  stall_fetch;
    logic [ADDR_WIDTH-1:0] imm_addr;

`ifdef DECODE_HAZARD_EN
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t                state;
    state_t                state_next;
    logic [WORD_WIDTH-1:0] skid_inst;
    logic [ADDR_WIDTH-1:0] skid_next_pc;
    logic [5:0]            in_op;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= RUN;
        else       state <= state_next;
    end

    // Next state: flush > stall > redirect > hazard > normal load
    always_comb begin
        state_next = state;
        if (bus.i_flush)      state_next = RUN;
        else if (bus.i_stall) state_next = state;
        else if (redirect)    state_next = RUN;
        else if (hazard)      state_next = HOLD;
        else                  state_next = RUN;
    end

    // Incoming source (fetch in RUN, skid in HOLD) and load-use detection;
    // in HOLD the output register is a bubble, so no hazard can arise there
    always_comb begin
        in_valid   = bus.i_valid;
        in_inst    = bus.i_inst;
        in_next_pc = bus.i_next_pc;
        if (state == HOLD) begin
            in_valid   = 1'b1;
            in_inst    = skid_inst;
            in_next_pc = skid_next_pc;
        end
        in_op  = in_inst[31:26];
        hazard = out_valid && (out_opcode == OP_LOAD) && (out_rd != '0) &&
                 in_valid && ((in_op == OP_ALU) || (in_op == OP_STORE)) &&
                 ((in_inst[20:16] == out_rd) || (in_inst[15:11] == out_rd));
    end

    // Skid buffer: captures the stalled instruction on a hazard
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            skid_inst    <= '0;
            skid_next_pc <= '0;
        end else if (bus.i_flush) begin
            skid_inst    <= '0;
            skid_next_pc <= '0;
        end else if (bus.i_stall) begin
            skid_inst    <= skid_inst;
            skid_next_pc <= skid_next_pc;
        end else if (hazard && !redirect) begin
            skid_inst    <= in_inst;
            skid_next_pc <= in_next_pc;
        end else begin
            skid_inst    <= '0;
            skid_next_pc <= '0;
        end
    end
`else
    // Hazard logic absent: incoming is always the fetch output
    always_comb begin
        in_valid   = bus.i_valid;
        in_inst    = bus.i_inst;
        in_next_pc = bus.i_next_pc;
        hazard     = 1'b0;
    end
`endif

    // Output register with the per-edge priority chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
        end else if (bus.i_flush) begin
            out_valid <= 1'b0;
        end else if (bus.i_stall) begin
            out_valid <= out_valid;
        end else if (redirect || hazard) begin
            out_valid <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            out_opcode <= in_inst[31:26];
            out_rd     <= in_inst[25:21];
            out_rs1    <= in_inst[20:16];
            out_rs2    <= in_inst[15:11];
            out_imm    <= {{(WORD_WIDTH-16){in_inst[15]}}, in_inst[15:0]};
            out_pc     <= in_next_pc - INST_BYTES;
        end
    end

    // Combinational outputs derived from the output register and stall inputs
    always_comb begin
        redirect    = out_valid && (out_opcode == OP_JMP);
        illegal     = out_valid && (out_opcode > OP_STORE);
        stall_fetch = bus.i_stall | hazard;
        imm_addr    = ADDR_WIDTH'($signed(out_imm));
    end

    assign bus.o_valid       = out_valid;
    assign bus.o_opcode      = out_opcode;
    assign bus.o_rd          = out_rd;
    assign bus.o_rs1         = out_rs1;
    assign bus.o_rs2         = out_rs2;
    assign bus.o_imm         = out_imm;
    assign bus.o_pc          = out_pc;
    assign bus.o_illegal     = illegal;
    assign bus.o_redirect    = redirect;
    assign bus.o_redirect_pc = out_pc + INST_BYTES + (imm_addr << 2);
    assign bus.o_stall_fetch = stall_fetch;
endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: expected output-register contents are queued
// as each edge's stimulus is driven and compared #1 after that edge.
module tb_decode;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    decode_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

    decode #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

`ifdef DECODE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  last_exp;
    string cur;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", cur, tag, got, want);
        end
    endtask

    function automatic exp_t decode_exp(input logic [31:0] inst, input logic [31:0] npc);
        exp_t e;
        e.valid  = 1'b1;
        e.opcode = inst[31:26];
        e.rd     = inst[25:21];
        e.rs1    = inst[20:16];
        e.rs2    = inst[15:11];
        e.imm    = {{16{inst[15]}}, inst[15:0]};
        e.pc     = npc - 32'd4;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] npc);
        bus.i_valid   = v;
        bus.i_inst    = inst;
        bus.i_next_pc = npc;
    endtask

    task automatic push_inst(input logic [31:0] inst, input logic [31:0] npc);
        last_exp = decode_exp(inst, npc);
        exp_q.push_back(last_exp);
    endtask

    task automatic push_bubble();
        last_exp.valid = 1'b0;
        exp_q.push_back(last_exp);
    endtask

    task automatic push_hold();
        exp_q.push_back(last_exp);
    endtask

    // One clock edge, then compare the output register against the queue
    task automatic tick();
        exp_t e;
        @(posedge i_clk);
        #1;
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("valid", bus.o_valid, e.valid);
            check("illegal", bus.o_illegal, e.valid && (e.opcode > 6'd4));
            check("redirect", bus.o_redirect, e.valid && (e.opcode == 6'd2));
            if (e.valid) begin
                check("opcode", bus.o_opcode, e.opcode);
                check("rd", bus.o_rd, e.rd);
                check("rs1", bus.o_rs1, e.rs1);
                check("rs2", bus.o_rs2, e.rs2);
                check("imm", bus.o_imm, e.imm);
                check("pc", bus.o_pc, e.pc);
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_opcode", bus.o_opcode, 6'd0);
        check("rst_rd", bus.o_rd, 5'd0);
        check("rst_rs1", bus.o_rs1, 5'd0);
        check("rst_rs2", bus.o_rs2, 5'd0);
        check("rst_imm", bus.o_imm, 32'd0);
        check("rst_pc", bus.o_pc, 32'd0);
        check("rst_redirect", bus.o_redirect, 1'b0);
        check("rst_illegal", bus.o_illegal, 1'b0);
        check("rst_stall_fetch", bus.o_stall_fetch, bus.i_stall);
    endtask

    initial begin
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive(1'b1, 32'h0422_1800, 32'h104);
        last_exp = '{valid: 1'b0, opcode: 6'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                     imm: 32'd0, pc: 32'd0};

        // Reset state, including stall pass-through while in reset
        cur = "reset";
        #2;
        check_reset_outputs();
        bus.i_stall = 1'b1;
        #1;
        check("stall_fetch_passthru", bus.o_stall_fetch, 1'b1);
        bus.i_stall = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Basic ALU decode, latency 1
        cur = "alu";
        drive(1'b1, 32'h0422_1800, 32'h104);
        push_inst(32'h0422_1800, 32'h104);
        tick();

        // Stall holds everything for 3 cycles, flush overrides stall
        cur = "stall";
        bus.i_stall = 1'b1;
        drive(1'b1, 32'h0CA1_0010, 32'h504);
        #1;
        check("stall_fetch", bus.o_stall_fetch, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push_hold();
            tick();
        end
        cur = "flush";
        bus.i_flush = 1'b1;
        push_bubble();
        tick();
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b0;

        // JMP with negative offset, then wrong-path drop
        cur = "jmp_neg";
        drive(1'b1, 32'h0800_FFFF, 32'h204);
        push_inst(32'h0800_FFFF, 32'h204);
        tick();
        check("redirect_pc", bus.o_redirect_pc, 32'h200);
        drive(1'b1, 32'h0422_1800, 32'h208);
        push_bubble();
        tick();

        // JMP with positive offset
        cur = "jmp_pos";
        drive(1'b1, 32'h0800_0003, 32'h304);
        push_inst(32'h0800_0003, 32'h304);
        tick();
        check("redirect_pc", bus.o_redirect_pc, 32'h310);
        drive(1'b0, 32'h0, 32'h0);
        push_bubble();
        tick();

        // Load-use: LOAD rd=5 then ALU rs1=5
        cur = "load_use";
        drive(1'b1, 32'h0CA1_0010, 32'h404);
        push_inst(32'h0CA1_0010, 32'h404);
        tick();
        drive(1'b1, 32'h04C5_3800, 32'h408);
        #1;
        check("stall_fetch", bus.o_stall_fetch, HZ);
        if (HZ) begin
            push_bubble();
            tick();
            drive(1'b0, 32'h0, 32'h0);
            #1;
            check("stall_fetch_hold", bus.o_stall_fetch, 1'b0);
            push_inst(32'h04C5_3800, 32'h408);
            tick();
        end else begin
            push_inst(32'h04C5_3800, 32'h408);
            tick();
            drive(1'b0, 32'h0, 32'h0);
            push_bubble();
            tick();
        end

        // LOAD to r0 never creates a hazard
        cur = "load_r0";
        drive(1'b1, 32'h0C01_0010, 32'h804);
        push_inst(32'h0C01_0010, 32'h804);
        tick();
        drive(1'b1, 32'h0440_0000, 32'h808);
        #1;
        check("stall_fetch", bus.o_stall_fetch, 1'b0);
        push_inst(32'h0440_0000, 32'h808);
        tick();

        // LOAD rd=7 then STORE rs2=7, then asynchronous reset (mid-HOLD when enabled)
        cur = "store_hazard";
        drive(1'b1, 32'h0CE0_0000, 32'h604);
        push_inst(32'h0CE0_0000, 32'h604);
        tick();
        drive(1'b1, 32'h1001_3800, 32'h608);
        #1;
        check("stall_fetch", bus.o_stall_fetch, HZ);
        if (HZ) push_bubble();
        else    push_inst(32'h1001_3800, 32'h608);
        tick();
        cur = "async_reset";
        drive(1'b0, 32'h0, 32'h0);
        i_rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        last_exp.valid = 1'b0;
        push_bubble();
        tick();
        push_bubble();
        tick();

        // Illegal opcode 0x3F
        cur = "illegal";
        drive(1'b1, 32'hFC00_0000, 32'h704);
        push_inst(32'hFC00_0000, 32'h704);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        push_bubble();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
